// File: rtl/adder.sv
// PC adder: combinational old_pc + (offset << OFFSET_SHIFT) with carry/overflow,
// plus a registered copy with a valid flag for the next pipeline stage.
module adder #(
  parameter int WIDTH        = 32,
  parameter int OFFSET_SHIFT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [0:WIDTH-1] old_pc,
  input  logic [0:WIDTH-1] offset,
  output logic [0:WIDTH-1] new_pc,
  output logic             carry,
  output logic             ovf,
  output logic [0:WIDTH-1] new_pc_r,
  output logic             carry_r,
  output logic             ovf_r,
  output logic             valid_r
);

  // Bit 0 is the MSB, so a left shift moves bits toward index 0 and the
  // extra sum bit at index 0 of sum_ext is the carry-out.
  logic [0:WIDTH-1] off_eff;
  logic [0:WIDTH]   sum_ext;

  always_comb begin
    off_eff = offset << OFFSET_SHIFT;
    sum_ext = {1'b0, old_pc} + {1'b0, off_eff};
    new_pc  = sum_ext[1:WIDTH];
    carry   = sum_ext[0];
    ovf     = (old_pc[0] == off_eff[0]) && (sum_ext[1] != old_pc[0]);
  end

  logic [0:WIDTH-1] new_pc_q, new_pc_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  // Capture on en; otherwise everything (valid included) holds.
  always_comb begin
    new_pc_d = new_pc_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
    if (en) begin
      new_pc_d = new_pc;
      carry_d  = carry;
      ovf_d    = ovf;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      new_pc_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      new_pc_q <= new_pc_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  assign new_pc_r = new_pc_q;
  assign carry_r  = carry_q;
  assign ovf_r    = ovf_q;
  assign valid_r  = valid_q;

endmodule

// File: tb/tb_adder.sv
// Bench for adder: directed literal cases, then randomized traffic compared
// every cycle against an arithmetic model and a queue of captured sums.
module tb_adder;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [W-1:0]  old_pc;
  logic [W-1:0]  offset;
  logic [W-1:0]  new_pc, new_pc_r, new_pc2, new_pc_r2;
  logic          carry, ovf, carry_r, ovf_r, valid_r;
  logic          carry2, ovf2, carry_r2, ovf_r2, valid_r2;

  int errors = 0;
  int checks = 0;
  bit clk_run = 1'b0;
  bit cmp_on  = 1'b0;

  // Captured {ovf, carry, sum}; the newest entry is what the registers hold.
  logic [W+1:0] exp_q[$];
  logic [W+1:0] exp_q2[$];

  adder #(.WIDTH(W), .OFFSET_SHIFT(0)) dut (
    .clk(clk), .reset(reset), .en(en), .old_pc(old_pc), .offset(offset),
    .new_pc(new_pc), .carry(carry), .ovf(ovf),
    .new_pc_r(new_pc_r), .carry_r(carry_r), .ovf_r(ovf_r), .valid_r(valid_r)
  );

  adder #(.WIDTH(W), .OFFSET_SHIFT(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .old_pc(old_pc), .offset(offset),
    .new_pc(new_pc2), .carry(carry2), .ovf(ovf2),
    .new_pc_r(new_pc_r2), .carry_r(carry_r2), .ovf_r(ovf_r2), .valid_r(valid_r2)
  );

  // clock/reset block
  initial begin
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  // Plain arithmetic reference: widen to 64 bits and range-check.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input int sh);
    logic [W-1:0] offe;
    longint       u, s;
    bit           c, v;
    offe = b << sh;
    u = longint'({32'd0, a}) + longint'({32'd0, offe});
    s = longint'($signed(a)) + longint'($signed(offe));
    c = (u >= 64'sh1_0000_0000);
    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {v, c, u[W-1:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: model register contents
  always @(posedge reset) begin
    exp_q.delete();
    exp_q2.delete();
  end

  always @(posedge clk) begin
    if (!reset && en) begin
      exp_q.push_back(model(old_pc, offset, 0));
      exp_q2.push_back(model(old_pc, offset, 2));
    end
  end

  // compare process
  always @(negedge clk) begin
    if (cmp_on) begin
      logic [W+1:0] m, m2, r, r2;
      m  = model(old_pc, offset, 0);
      m2 = model(old_pc, offset, 2);
      r  = (exp_q.size()  != 0) ? exp_q[$]  : '0;
      r2 = (exp_q2.size() != 0) ? exp_q2[$] : '0;
      check("new_pc",    64'(new_pc), 64'(m[W-1:0]));
      check("carry",     64'(carry),  64'(m[W]));
      check("ovf",       64'(ovf),    64'(m[W+1]));
      check("new_pc_s2", 64'(new_pc2), 64'(m2[W-1:0]));
      check("carry_s2",  64'(carry2),  64'(m2[W]));
      check("ovf_s2",    64'(ovf2),    64'(m2[W+1]));
      check("new_pc_r",  64'(new_pc_r), 64'(r[W-1:0]));
      check("carry_r",   64'(carry_r),  64'(r[W]));
      check("ovf_r",     64'(ovf_r),    64'(r[W+1]));
      check("valid_r",   64'(valid_r),  64'(exp_q.size() != 0));
      check("new_pc_r_s2", 64'(new_pc_r2), 64'(r2[W-1:0]));
      check("valid_r_s2",  64'(valid_r2),  64'(exp_q2.size() != 0));
    end
  end

  // driver tasks
  task automatic set_in(input logic [W-1:0] a, input logic [W-1:0] b);
    old_pc = a;
    offset = b;
    #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    en = 1'b0;
    old_pc = '0;
    offset = '0;

    // Combinational cases, no clock running.
    set_in(32'd0, 32'd0);
    check("t1_new_pc", 64'(new_pc), 64'd0);
    check("t1_carry", 64'(carry), 64'd0);
    check("t1_ovf", 64'(ovf), 64'd0);
    check("rst_new_pc_r", 64'(new_pc_r), 64'd0);
    check("rst_valid_r", 64'(valid_r), 64'd0);
    set_in(32'd5, 32'd10);
    check("t2_new_pc", 64'(new_pc), 64'd15);
    set_in(32'd20, 32'd4);
    check("t3_new_pc", 64'(new_pc), 64'd24);
    set_in(32'hFFFF_FFFF, 32'd1);
    check("t4a_new_pc", 64'(new_pc), 64'd0);
    check("t4a_carry", 64'(carry), 64'd1);
    check("t4a_ovf", 64'(ovf), 64'd0);
    set_in(32'h7FFF_FFFF, 32'd1);
    check("t4b_new_pc", 64'(new_pc), 64'h8000_0000);
    check("t4b_ovf", 64'(ovf), 64'd1);
    set_in(32'h100, 32'hFFFF_FFFC);
    check("t5_new_pc", 64'(new_pc), 64'hFC);
    check("t5_carry", 64'(carry), 64'd1);
    check("t5_ovf", 64'(ovf), 64'd0);
    set_in(32'h100, 32'd3);
    check("t5_shift2", 64'(new_pc2), 64'h10C);

    // Start clocking, release reset between edges.
    clk_run = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    cmp_on = 1'b1;

    @(negedge clk);
    #1;
    old_pc = 32'd5;
    offset = 32'd10;
    en = 1'b1;
    @(posedge clk);
    #2;
    en = 1'b0;
    old_pc = 32'd77;
    offset = 32'd3;
    @(negedge clk);
    #1;
    check("t6_new_pc_r", 64'(new_pc_r), 64'd15);
    check("t6_valid_r", 64'(valid_r), 64'd1);
    @(posedge clk);
    #2;
    old_pc = 32'd1000;
    @(negedge clk);
    #1;
    check("t6_hold", 64'(new_pc_r), 64'd15);
    reset = 1'b1;
    #1;
    check("t6_rst_new_pc_r", 64'(new_pc_r), 64'd0);
    check("t6_rst_valid_r", 64'(valid_r), 64'd0);
    check("t6_rst_comb", 64'(new_pc), 64'd1003);
    #1 reset = 1'b0;

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 39) == 0) reset = 1'b1;
      en = ($urandom_range(0, 2) != 0);
      old_pc = pick();
      offset = pick();
    end

    @(negedge clk);
    #1;
    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
